// File: rtl/transmitter_control_unit_pkg.sv
// Shared UART definitions: FSM state encoding, default timing and the per-state line level.
// Imported by both the transmitter and the receiver.
package transmitter_control_unit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned UART_CLKS_PER_BIT        = 16;
   localparam int unsigned UART_BAUD_COUNTER_WIDTH  = 4;
   localparam int unsigned UART_DATA_WIDTH          = 8;

   // Serial line level for a given state; data_bit is only used in DATA.
   function automatic logic tx_level(input uart_state_e state, input logic data_bit);
      logic level;
      level = 1'b1;
      unique case (state)
         IDLE:    level = 1'b1;
         START:   level = 1'b0;
         DATA:    level = data_bit;
         STOP:    level = 1'b1;
         default: level = 1'b1;
      endcase
      return level;
   endfunction

endpackage

// File: rtl/transmitter_control_unit_if.sv
// Byte handshake into the UART transmitter.
// A byte moves when i_valid and o_ready are both high at a rising clock edge; i_data is only
// looked at on that edge, and i_valid may be raised or dropped freely while o_ready is low.
interface transmitter_control_unit_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_ready;

   modport master (output i_valid, output i_data, input o_ready);
   modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/transmitter_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module transmitter_baud_counter #(
   parameter int CLKS_PER_BIT       = 16,
   parameter int BAUD_COUNTER_WIDTH = 4
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_equal
);

   localparam logic [BAUD_COUNTER_WIDTH-1:0] LAST_COUNT =
      BAUD_COUNTER_WIDTH'(CLKS_PER_BIT - 1);

   logic [BAUD_COUNTER_WIDTH-1:0] count_q;
   logic [BAUD_COUNTER_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable) begin
         count_d = (count_q == LAST_COUNT) ? '0 : count_q + BAUD_COUNTER_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_equal = i_enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/transmitter_control_unit.sv
// UART transmitter control: frame FSM, payload shift register and registered serial line.
// The bit index lives in an external bit counter that reports the last data bit via i_equal_MSB.
module transmitter_control_unit
   import transmitter_control_unit_pkg::*;
#(
   parameter int CLKS_PER_BIT       = UART_CLKS_PER_BIT,
   parameter int BAUD_COUNTER_WIDTH = UART_BAUD_COUNTER_WIDTH,
   parameter int DATA_WIDTH         = UART_DATA_WIDTH
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   transmitter_control_unit_if.slave    tx_in,
   input  logic                         i_equal_MSB,
   output logic                         o_equal,
   output logic                         o_state_is_START,
   output logic                         o_state_is_DATA,
   output logic                         o_tx,
   output logic                         o_frame_done
);

   uart_state_e           state_q;
   uart_state_e           state_d;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_d;
   logic                  tx_q;
   logic                  tx_d;
   logic                  accept;
   logic                  baud_equal;

   assign accept = tx_in.i_valid && (state_q == IDLE);

   transmitter_baud_counter #(
      .CLKS_PER_BIT       (CLKS_PER_BIT),
      .BAUD_COUNTER_WIDTH (BAUD_COUNTER_WIDTH)
   ) u_baud_counter (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (accept),
      .i_enable (state_q != IDLE),
      .o_equal  (baud_equal)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)                     state_d = START;
         START:   if (baud_equal)                 state_d = DATA;
         DATA:    if (baud_equal && i_equal_MSB)  state_d = STOP;
         STOP:    if (baud_equal)                 state_d = IDLE;
         default:                                 state_d = IDLE;
      endcase
   end

   // o_tx is computed from the next state/shift so the registered line lines up with state_q.
   always_comb begin
      shift_d = shift_q;
      if (accept) begin
         shift_d = tx_in.i_data;
      end else if ((state_q == DATA) && baud_equal && !i_equal_MSB) begin
         shift_d = shift_q >> 1;
      end
      tx_d = tx_level(state_d, shift_d[0]);
   end

   always_comb begin
      tx_in.o_ready    = (state_q == IDLE);
      o_state_is_START = (state_q == START);
      o_state_is_DATA  = (state_q == DATA);
      o_equal          = baud_equal;
      o_frame_done     = baud_equal && (state_q == STOP);
      o_tx             = tx_q;
   end

endmodule

// File: tb/tb_transmitter_control_unit.sv
// Self-checking bench for transmitter_control_unit: frame-timeline model, serial-line
// scoreboard, directed frame scenarios and a randomized traffic phase with random resets.
module tb_transmitter_control_unit;

   localparam int CLKS  = 4;
   localparam int BCW   = 2;
   localparam int DW    = 8;
   localparam int FRAME = (DW + 2) * CLKS;

   logic clk;
   logic rst;
   logic eq_msb;
   logic o_equal;
   logic st_start;
   logic st_data;
   logic o_tx;
   logic o_fd;
   logic [3:0] bit_idx;

   int n_cmp = 0;
   int n_bad = 0;

   transmitter_control_unit_if #(.DATA_WIDTH(DW)) tx_if ();

   transmitter_control_unit #(
      .CLKS_PER_BIT       (CLKS),
      .BAUD_COUNTER_WIDTH (BCW),
      .DATA_WIDTH         (DW)
   ) dut (
      .i_clock          (clk),
      .i_reset          (rst),
      .tx_in            (tx_if),
      .i_equal_MSB      (eq_msb),
      .o_equal          (o_equal),
      .o_state_is_START (st_start),
      .o_state_is_DATA  (st_data),
      .o_tx             (o_tx),
      .o_frame_done     (o_fd)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Companion bit counter: advances on each baud tick inside DATA.
   always @(posedge clk) begin
      if (rst || !st_data) bit_idx <= '0;
      else if (o_equal)    bit_idx <= bit_idx + 4'd1;
   end
   assign eq_msb = st_data && (bit_idx == 4'(DW - 1));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   // Frame timeline: t counts cycles since acceptance; bit slot = t / CLKS.
   logic       m_on = 1'b0;
   logic       m_busy = 1'b0;
   int         m_t = 0;
   logic [7:0] m_byte = '0;
   logic [7:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_on   = 1'b1;
         m_busy = 1'b0;
         m_t    = 0;
         exp_q.delete();
      end else if (!m_busy) begin
         if (tx_if.i_valid) begin
            m_busy = 1'b1;
            m_t    = 0;
            m_byte = tx_if.i_data;
            exp_q.push_back(tx_if.i_data);
         end
      end else begin
         m_t++;
         if (m_t == FRAME) m_busy = 1'b0;
      end
   end

   // {ready, tx, equal, frame_done, start, data}
   function automatic logic [5:0] model_outputs();
      int   slot;
      logic tx;
      if (!m_busy) return 6'b110000;
      slot = m_t / CLKS;
      if (slot == 0)       tx = 1'b0;
      else if (slot <= DW) tx = m_byte[slot - 1];
      else                 tx = 1'b1;
      return {1'b0, tx, (m_t % CLKS) == CLKS - 1, m_t == FRAME - 1,
              slot == 0, (slot >= 1) && (slot <= DW)};
   endfunction

   always @(negedge clk) begin
      if (m_on) begin
         check("cycle_outputs", {58'd0, tx_if.o_ready, o_tx, o_equal, o_fd, st_start, st_data},
               {58'd0, model_outputs()});
      end
   end

   // ---------------- scoreboard: serial-line receiver ----------------
   logic       r_on = 1'b0;
   int         r_c = 0;
   logic [7:0] r_byte = '0;
   int         rx_frames = 0;

   always @(negedge clk) begin
      if (rst || !m_on) begin
         r_on = 1'b0;
      end else if (!r_on) begin
         if (o_tx == 1'b0) begin
            r_on = 1'b1;
            r_c  = 0;
         end
      end else begin
         r_c++;
         if ((r_c % CLKS == 2) && (r_c / CLKS >= 1) && (r_c / CLKS <= DW))
            r_byte[r_c / CLKS - 1] = o_tx;
         if (r_c == (DW + 1) * CLKS + 2) begin
            check("rx_stop_bit", {63'd0, o_tx}, 64'd1);
            check("rx_queue_nonempty", {63'd0, exp_q.size() > 0}, 64'd1);
            if (exp_q.size() > 0) check("rx_byte", {56'd0, r_byte}, {56'd0, exp_q.pop_front()});
            rx_frames++;
            r_on = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready();
      int n = 0;
      while (!tx_if.o_ready && n < 200) begin
         tick();
         n++;
      end
      check("wait_ready", {63'd0, tx_if.o_ready}, 64'd1);
   endtask

   task automatic send(input logic [7:0] b);
      wait_ready();
      tx_if.i_valid = 1'b1;
      tx_if.i_data  = b;
      tick();
      tx_if.i_valid = 1'b0;
      tx_if.i_data  = 8'($urandom);
   endtask

   // 8'hA5 frame against hand-derived line levels and timing.
   task automatic run_a5();
      logic [FRAME-1:0] txc;
      logic [9:0]       exp_bits;
      logic [3:0]       seg;
      int eqc = 0, dc = 0, fdpos = 0, last_eq = 0, gap_bad = 0;
      exp_bits = 10'b11_0100_1010;
      send(8'hA5);
      for (int i = 1; i <= FRAME; i++) begin
         txc[i - 1] = o_tx;
         if (o_equal) begin
            eqc++;
            if (last_eq > 0 && i - last_eq != CLKS) gap_bad++;
            last_eq = i;
         end
         if (st_data) dc++;
         if (o_fd) fdpos = i;
         tick();
      end
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < CLKS; k++) seg[k] = txc[b * CLKS + k];
         check($sformatf("a5_bit%0d", b), {60'd0, seg}, exp_bits[b] ? 64'hF : 64'h0);
      end
      check("a5_equal_count", 64'(eqc), 64'd10);
      check("a5_equal_spacing_errors", 64'(gap_bad), 64'd0);
      check("a5_data_cycles", 64'(dc), 64'd32);
      check("a5_frame_done_cycle", 64'(fdpos), 64'd40);
      check("a5_ready_cycle41", {63'd0, tx_if.o_ready}, 64'd1);
   endtask

   task automatic run_back_to_back();
      int n = 0, idle = 0, ones = 0, dcyc = 0;
      wait_ready();
      tx_if.i_valid = 1'b1;
      tx_if.i_data  = 8'h00;
      tick();
      tx_if.i_data  = 8'hFF;
      while (!tx_if.o_ready && n < 100) begin
         tick();
         n++;
      end
      while (tx_if.o_ready && idle < 10) begin
         idle++;
         tick();
      end
      tx_if.i_valid = 1'b0;
      check("b2b_idle_cycles", 64'(idle), 64'd1);
      for (int i = 0; i < FRAME; i++) begin
         if (st_data) begin
            dcyc++;
            if (o_tx) ones++;
         end
         tick();
      end
      check("b2b_second_frame_ones", 64'(ones), 64'd32);
      check("b2b_second_frame_data_cycles", 64'(dcyc), 64'd32);
   endtask

   task automatic run_mid_frame_reset();
      int fds = 0;
      send(8'($urandom));
      for (int i = 1; i < 18; i++) begin
         if (o_fd) fds++;
         tick();
      end
      if (o_fd) fds++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_mid_tx", {63'd0, o_tx}, 64'd1);
      check("reset_mid_ready", {63'd0, tx_if.o_ready}, 64'd1);
      if (o_fd) fds++;
      tick();
      if (o_fd) fds++;
      check("reset_mid_no_frame_done", 64'(fds), 64'd0);
   endtask

   task automatic run_ignore_inputs();
      send(8'h3C);
      for (int i = 0; i < FRAME; i++) begin
         tx_if.i_valid = 1'($urandom);
         tx_if.i_data  = 8'($urandom);
         tick();
      end
      tx_if.i_valid = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst           = 1'b1;
      tx_if.i_valid = 1'b0;
      tx_if.i_data  = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_ready", {63'd0, tx_if.o_ready}, 64'd1);
      check("reset_tx", {63'd0, o_tx}, 64'd1);
      check("reset_equal", {63'd0, o_equal}, 64'd0);
      check("reset_frame_done", {63'd0, o_fd}, 64'd0);
      tick();

      run_a5();
      run_back_to_back();
      run_mid_frame_reset();
      run_a5();
      run_ignore_inputs();

      for (int i = 0; i < 2500; i++) begin
         tx_if.i_valid = ($urandom_range(0, 3) != 0);
         tx_if.i_data  = 8'($urandom);
         rst           = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst           = 1'b0;
      tx_if.i_valid = 1'b0;
      wait_ready();
      repeat (2 * CLKS) tick();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check("frames_received", {63'd0, rx_frames >= 20}, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/transmitter_control_unit.md
TRANSMITTER_CONTROL_UNIT -- requirements
Module: transmitter_control_unit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..2^BAUD_COUNTER_WIDTH.
REQ-002 Parameter BAUD_COUNTER_WIDTH, default 4: width of the internal baud counter.
REQ-003 Parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-004 i_clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1  upstream has a byte to send.
REQ-007 i_data  input  DATA_WIDTH  byte to send; sampled only on acceptance.
REQ-008 o_ready  output  1  block can accept a byte this cycle.
REQ-009 i_equal_MSB  input  1  from the bit counter; high while the current data bit index equals DATA_WIDTH-1.
REQ-010 o_equal  output  1  one-cycle baud tick: last cycle of the current bit period; drives the bit counter.
REQ-011 o_state_is_START  output  1  FSM is in START.
REQ-012 o_state_is_DATA  output  1  FSM is in DATA.
REQ-013 o_tx  output  1  serial line; idles high.
REQ-014 o_frame_done  output  1  one-cycle pulse on the last cycle of STOP.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA and STOP; state, baud counter, shift register and o_tx SHALL all be registered.
REQ-016 o_ready SHALL be 1 exactly when state==IDLE; acceptance occurs when i_valid and o_ready are high at a rising edge.
REQ-017 On acceptance, i_data SHALL load into the shift register, the baud counter SHALL clear, and the state SHALL become START at that edge.
REQ-018 In non-IDLE states the baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; o_equal SHALL be high exactly when count==CLKS_PER_BIT-1 and the state is not IDLE.
REQ-019 Transitions SHALL occur only on o_equal: START->DATA; DATA->STOP when i_equal_MSB=1, otherwise remain in DATA and shift the register right by one; STOP->IDLE.
REQ-020 Each of START, each DATA bit and STOP SHALL last exactly CLKS_PER_BIT cycles, so a frame lasts (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-021 o_tx SHALL be 1 in IDLE, 0 in START, shift-register bit 0 in DATA (LSB first), and 1 in STOP, aligned cycle-exactly with the state.
REQ-022 o_frame_done SHALL equal o_equal gated by state==STOP.
REQ-023 Back-to-back frames: with i_valid held high, IDLE SHALL last exactly one cycle between frames.
REQ-024 i_valid and i_data SHALL be ignored outside IDLE; no byte is queued.
REQ-025 The baud counter SHALL wrap with no overflow; arithmetic is BAUD_COUNTER_WIDTH bits, unsigned.

Reset
REQ-026 While i_reset=1 at an edge, the block SHALL go to IDLE, with baud counter=0, shift register=0, o_tx=1, o_equal=0, o_frame_done=0 and o_ready=1 from the next cycle.
REQ-027 Reset mid-frame SHALL abort the frame with no o_frame_done pulse; reset SHALL take priority over acceptance in the same cycle.

Structure
REQ-028 The state encoding (IDLE=0, START=1, DATA=2, STOP=3, 2 bits) and the default CLKS_PER_BIT SHALL live in a shared UART package used by transmitter and receiver.
REQ-029 The baud counter SHALL be one sub-module, transmitter_baud_counter (clear, enable, o_equal); the FSM and shift register stay in the top.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8, paired with the bit counter)
REQ-030 Accept 8'hA5 -> o_tx holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total); o_frame_done pulses on cycle 40; o_ready returns on cycle 41.
REQ-031 Hold i_valid high with 8'h00 then 8'hFF -> exactly one IDLE cycle between frames; second frame data bits are all 1.
REQ-032 Assert reset at cycle 18 of a frame -> o_tx=1 and o_ready=1 on the next cycle; no o_frame_done pulse; the next frame is correct.
REQ-033 Change i_data and toggle i_valid during DATA -> the transmitted byte is unchanged.
REQ-034 Count o_equal pulses per frame -> exactly 10, each one cycle wide, spaced 4 cycles apart; o_state_is_DATA is high for 32 cycles.
